// File: rtl/univ_register_pkg.sv
// -----------------------------------------------------------------------------
// univ_register_pkg
// Shared type definitions for the universal shift/load register.
//   op_e    : operation encoding driven on the op port
//   state_e : control states (IDLE accepts ops, SHIFT steps one bit per edge)
// -----------------------------------------------------------------------------
package univ_register_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'b00,
      LOAD = 2'b01,
      SHL  = 2'b10,   // toward MSB, fill enters at bit 0
      SHR  = 2'b11    // toward LSB, fill enters at bit WIDTH-1
   } op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage : univ_register_pkg

// File: rtl/univ_register.sv
// -----------------------------------------------------------------------------
// univ_register
// Universal register: parallel load, hold, and multi-cycle left/right shift
// by a programmable amount (one bit per clock), with serial fill.
//
// Parameters
//   WIDTH        data width (>= 2)
//   RESET_VALUE  contents of dout after reset
//   AW           shift-amount width, $clog2(WIDTH)+1
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   din          parallel load data
//   op           00 HOLD, 01 LOAD, 10 SHL, 11 SHR
//   op_valid     op request, only sampled while idle
//   amount       shift count, saturates at WIDTH
//   ser_in       serial fill bit, sampled on every shift edge
//   rotate       rotate request, latched when a shift is accepted
//   dout         register contents
//   sout         last bit shifted out
//   busy         high for every cycle spent shifting
//   done         one-cycle pulse after the edge that completes an op
// Build option
//   UNIV_REGISTER_ROTATE_EN : when defined, a latched rotate request makes the
//   fill bit equal to the bit shifted out; otherwise rotate is ignored.
// -----------------------------------------------------------------------------
module univ_register
   import univ_register_pkg::*;
#(
   parameter  int               WIDTH       = 8,
   parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int               AW          = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic [1:0]       op,
   input  logic             op_valid,
   input  logic [AW-1:0]    amount,
   input  logic             ser_in,
   input  logic             rotate,
   output logic [WIDTH-1:0] dout,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [AW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;
   logic             dir_right_q, dir_right_d;

   op_e              op_in;
   logic [AW-1:0]    amount_sat;
   logic             shift_out;
   logic             fill;
   logic [WIDTH-1:0] shifted;

`ifdef UNIV_REGISTER_ROTATE_EN
   logic             rot_q, rot_d;
`else
   logic             unused_rotate;
   assign unused_rotate = rotate;
`endif

   assign op_in      = op_e'(op);
   assign amount_sat = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;

   // One-bit shift datapath, driven by the direction latched at acceptance.
   always_comb begin
      shift_out = dir_right_q ? dout_q[0] : dout_q[WIDTH-1];
`ifdef UNIV_REGISTER_ROTATE_EN
      fill      = rot_q ? shift_out : ser_in;
`else
      fill      = ser_in;
`endif
      shifted   = dir_right_q ? {fill, dout_q[WIDTH-1:1]}
                              : {dout_q[WIDTH-2:0], fill};
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         dout_q      <= RESET_VALUE;
         sout_q      <= 1'b0;
         done_q      <= 1'b0;
         dir_right_q <= 1'b0;
`ifdef UNIV_REGISTER_ROTATE_EN
         rot_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         sout_q      <= sout_d;
         done_q      <= done_d;
         dir_right_q <= dir_right_d;
`ifdef UNIV_REGISTER_ROTATE_EN
         rot_q       <= rot_d;
`endif
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      dout_d      = dout_q;
      sout_d      = sout_q;
      done_d      = 1'b0;
      dir_right_d = dir_right_q;
`ifdef UNIV_REGISTER_ROTATE_EN
      rot_d       = rot_q;
`endif
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               case (op_in)
                  LOAD: begin
                     dout_d = din;
                     done_d = 1'b1;
                  end
                  HOLD: done_d = 1'b1;
                  SHL, SHR: begin
                     if (amount_sat == '0) begin
                        done_d = 1'b1;
                     end else begin
                        // Accepting edge only latches; shifting starts next edge.
                        count_d     = amount_sat;
                        dir_right_d = (op_in == SHR);
`ifdef UNIV_REGISTER_ROTATE_EN
                        rot_d       = rotate;
`endif
                        state_d     = SHIFT;
                     end
                  end
                  default: ;
               endcase
            end
         end
         SHIFT: begin
            dout_d  = shifted;
            sout_d  = shift_out;
            count_d = count_q - AW'(1);
            if (count_q == AW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      dout = dout_q;
      sout = sout_q;
      busy = (state_q == SHIFT);
      done = done_q;
   end

endmodule : univ_register
